// File: rtl/intra4x4_mode_decision.sv
// Intra 4x4 luma mode decision.
// Evaluates V, H, DC and DDL predictions one row per cycle over a latched 4x4
// source block, accumulates a SAD per mode and keeps the lowest-SAD mode. Ties
// keep the lower mode number.
// Ports:
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_start              request, sampled only while idle
//   i_mb[16]             source block, index row*4+col
//   i_toppixels[8]       T0..T7 (T4..T7 above-right)
//   i_leftpixels[5]      [0] top-left corner, [1..4] L0..L3
//   o_ready              high while idle
//   o_done               one-cycle pulse when the result outputs update
//   o_bestmode           0 V, 1 H, 2 DC, 3 DDL
//   o_bestsad            SAD of the winning mode
//   o_pred[16]           winning prediction block
//   o_residual[16]       signed mb - pred
module intra4x4_mode_decision (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [7:0]        i_mb         [16],
  input  logic [7:0]        i_toppixels  [8],
  input  logic [7:0]        i_leftpixels [5],
  output logic              o_ready,
  output logic              o_done,
  output logic [1:0]        o_bestmode,
  output logic [11:0]       o_bestsad,
  output logic [7:0]        o_pred       [16],
  output logic signed [8:0] o_residual   [16]
);

  typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [7:0]        r_mb        [16];
  logic [7:0]        r_top       [8];
  logic [7:0]        r_left      [5];
  logic [7:0]        r_cand      [16];
  logic [7:0]        r_best_pred [16];
  logic [1:0]        r_mode, r_row, r_best_mode;
  logic [11:0]       r_acc, r_best_sad;
  logic              r_done;
  logic [1:0]        r_out_mode;
  logic [11:0]       r_out_sad;
  logic [7:0]        r_out_pred  [16];
  logic signed [8:0] r_out_res   [16];

  logic [7:0]        w_pred_row  [4];
  logic [7:0]        w_bp_next   [16];
  logic [10:0]       w_dc_sum;
  logic [9:0]        w_row_sad;
  logic [11:0]       w_total, w_bs_next;
  logic [1:0]        w_bm_next;
  logic              w_last_row, w_take;

  assign w_last_row = (r_row == 2'd3);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StEval;
      StEval:  if (w_last_row && (r_mode == 2'd3)) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Row prediction for the current mode plus its SAD against the source row.
  always_comb begin
    logic [2:0] ia, ib, ic;
    logic [9:0] ddl_sum;
    logic [7:0] pix, ad;
    w_dc_sum  = 11'd4;
    w_row_sad = '0;
    for (int i = 0; i < 4; i++) begin
      w_dc_sum = w_dc_sum + {3'b0, r_top[i]} + {3'b0, r_left[i+1]};
    end
    for (int x = 0; x < 4; x++) begin
      ia = 3'(x) + {1'b0, r_row};
      ib = ia + 3'd1;
      // Bottom-right DDL pixel has no T8; substituting T7 gives T6 + 3*T7.
      ic = (ia == 3'd6) ? 3'd7 : ia + 3'd2;
      ddl_sum = {2'b0, r_top[ia]} + {1'b0, r_top[ib], 1'b0} + {2'b0, r_top[ic]} + 10'd2;
      unique case (r_mode)
        2'd0:    w_pred_row[x] = r_top[x];
        2'd1:    w_pred_row[x] = r_left[{1'b0, r_row} + 3'd1];
        2'd2:    w_pred_row[x] = w_dc_sum[10:3];
        default: w_pred_row[x] = ddl_sum[9:2];
      endcase
      pix = r_mb[{r_row, 2'(x)}];
      ad  = (pix >= w_pred_row[x]) ? pix - w_pred_row[x] : w_pred_row[x] - pix;
      w_row_sad = w_row_sad + {2'b0, ad};
    end
  end

  assign w_total = r_acc + {2'b0, w_row_sad};
  assign w_take  = w_last_row && ((r_mode == 2'd0) || (w_total < r_best_sad));

  // Best candidate after this cycle; the current row is not yet in r_cand.
  always_comb begin
    w_bs_next = w_take ? w_total : r_best_sad;
    w_bm_next = w_take ? r_mode  : r_best_mode;
    for (int i = 0; i < 16; i++) begin
      w_bp_next[i] = r_best_pred[i];
      if (w_take) begin
        w_bp_next[i] = (4'(i) >> 2 == {2'b0, r_row}) ? w_pred_row[i % 4] : r_cand[i];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_mode      <= '0;
      r_row       <= '0;
      r_acc       <= '0;
      r_best_mode <= '0;
      r_best_sad  <= '0;
      r_done      <= 1'b0;
      r_out_mode  <= '0;
      r_out_sad   <= '0;
      for (int i = 0; i < 16; i++) begin
        r_mb[i]        <= '0;
        r_cand[i]      <= '0;
        r_best_pred[i] <= '0;
        r_out_pred[i]  <= '0;
        r_out_res[i]   <= '0;
      end
      for (int i = 0; i < 8; i++) r_top[i] <= '0;
      for (int i = 0; i < 5; i++) r_left[i] <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_mb   <= i_mb;
            r_top  <= i_toppixels;
            r_left <= i_leftpixels;
            r_mode <= '0;
            r_row  <= '0;
            r_acc  <= '0;
          end
        end
        StEval: begin
          for (int x = 0; x < 4; x++) r_cand[{r_row, 2'(x)}] <= w_pred_row[x];
          if (w_last_row) begin
            r_acc       <= '0;
            r_row       <= '0;
            r_mode      <= r_mode + 2'd1;
            r_best_sad  <= w_bs_next;
            r_best_mode <= w_bm_next;
            r_best_pred <= w_bp_next;
            if (r_mode == 2'd3) begin
              r_done     <= 1'b1;
              r_out_mode <= w_bm_next;
              r_out_sad  <= w_bs_next;
              for (int i = 0; i < 16; i++) begin
                r_out_pred[i] <= w_bp_next[i];
                r_out_res[i]  <= {1'b0, r_mb[i]} - {1'b0, w_bp_next[i]};
              end
            end
          end else begin
            r_acc <= w_total;
            r_row <= r_row + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready    = (r_state == StIdle);
  assign o_done     = r_done;
  assign o_bestmode = r_out_mode;
  assign o_bestsad  = r_out_sad;
  assign o_pred     = r_out_pred;
  assign o_residual = r_out_res;

endmodule

// File: tb/tb_intra4x4_mode_decision.sv
// Directed bench for intra4x4_mode_decision: five hand-computed blocks, an
// ignored mid-evaluation start, and a mid-evaluation reset.
module tb_intra4x4_mode_decision;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        mb   [16];
  logic [7:0]        top  [8];
  logic [7:0]        left [5];
  logic              ready, done;
  logic [1:0]        bestmode;
  logic [11:0]       bestsad;
  logic [7:0]        pred [16];
  logic signed [8:0] residual [16];

  // Expected source and prediction for the block under test.
  int e_mb   [16];
  int e_pred [16];
  int checks = 0;
  int errors = 0;

  intra4x4_mode_decision dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_mb         (mb),
    .i_toppixels  (top),
    .i_leftpixels (left),
    .o_ready      (ready),
    .o_done       (done),
    .o_bestmode   (bestmode),
    .o_bestsad    (bestsad),
    .o_pred       (pred),
    .o_residual   (residual)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_inputs();
    for (int i = 0; i < 16; i++) mb[i] = 8'(e_mb[i]);
  endtask

  task automatic garble_inputs();
    for (int i = 0; i < 16; i++) mb[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) top[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) left[i] = 8'($urandom);
  endtask

  // Launch a block at the next edge, optionally re-pulse start after edge
  // pulse_at, and wait for done with a bounded budget.
  task automatic run_block(input string tag, input int pulse_at);
    int k;
    load_inputs();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_ready_low"}, int'(ready), 0);
    garble_inputs();
    k = 0;
    while (!done && k < 40) begin
      start = (pulse_at > 0 && k == pulse_at) ? 1'b1 : 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, "_latency"}, k, 16);
  endtask

  task automatic check_result(input string tag, input int mode, input int sad);
    check({tag, "_mode"}, int'(bestmode), mode);
    check({tag, "_sad"}, int'(bestsad), sad);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_pred%0d", tag, i), int'(pred[i]), e_pred[i]);
      check($sformatf("%s_res%0d", tag, i), int'(residual[i]), e_mb[i] - e_pred[i]);
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_ready_back"}, int'(ready), 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mb[i] = '0;
    for (int i = 0; i < 8; i++) top[i] = '0;
    for (int i = 0; i < 5; i++) left[i] = '0;
    #23;
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_sad", int'(bestsad), 0);
    check("rst_pred0", int'(pred[0]), 0);
    reset = 1'b0;

    // Flat block: every mode ties at SAD 0, mode 0 wins.
    for (int i = 0; i < 16; i++) begin e_mb[i] = 128; e_pred[i] = 128; end
    for (int i = 0; i < 8; i++) top[i] = 8'd128;
    for (int i = 0; i < 5; i++) left[i] = 8'd128;
    run_block("flat", 0);
    check_result("flat", 0, 0);

    // Vertical stripes.
    for (int i = 0; i < 8; i++) top[i] = 8'(10 * (i + 1));
    for (int i = 0; i < 5; i++) left[i] = 8'd200;
    for (int i = 0; i < 16; i++) begin e_mb[i] = 10 * (i % 4 + 1); e_pred[i] = e_mb[i]; end
    run_block("vert", 0);
    check_result("vert", 0, 0);

    // DC: (4*100 + 4*50 + 4) >> 3 = 75.
    for (int i = 0; i < 8; i++) top[i] = 8'd100;
    for (int i = 0; i < 5; i++) left[i] = 8'd50;
    for (int i = 0; i < 16; i++) begin e_mb[i] = 75; e_pred[i] = 75; end
    run_block("dc", 0);
    check_result("dc", 2, 0);

    // DDL over T[i] = 16i: p = 16(x+y) + 16, bottom-right = 108.
    for (int i = 0; i < 8; i++) top[i] = 8'(16 * i);
    for (int i = 0; i < 5; i++) left[i] = 8'd255;
    for (int i = 0; i < 16; i++) begin
      e_mb[i]   = 16 * (i % 4 + i / 4) + 16;
      e_pred[i] = e_mb[i];
    end
    e_mb[15] = 108;
    e_pred[15] = 108;
    run_block("ddl", 0);
    check_result("ddl", 3, 0);

    // Horizontal rows 0/50/100/150 with a +5 error in pixel 0; start
    // re-pulsed mid-evaluation must be ignored.
    for (int i = 0; i < 8; i++) top[i] = 8'd255;
    left[0] = 8'd255;
    for (int i = 1; i < 5; i++) left[i] = 8'(50 * (i - 1));
    for (int i = 0; i < 16; i++) begin e_mb[i] = 50 * (i / 4); e_pred[i] = e_mb[i]; end
    e_mb[0] = 5;
    run_block("horiz", 4);
    check_result("horiz", 1, 5);
    begin
      int extra = 0;
      for (int c = 0; c < 24; c++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("horiz_single_done", extra, 0);
    end

    // Reset during evaluation clears the held outputs.
    for (int i = 0; i < 8; i++) top[i] = 8'(10 * (i + 1));
    for (int i = 0; i < 5; i++) left[i] = 8'd200;
    for (int i = 0; i < 16; i++) mb[i] = 8'(10 * (i % 4 + 1));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mrst_ready", int'(ready), 1);
    check("mrst_done", int'(done), 0);
    check("mrst_mode", int'(bestmode), 0);
    check("mrst_sad", int'(bestsad), 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("mrst_pred%0d", i), int'(pred[i]), 0);
      check($sformatf("mrst_res%0d", i), int'(residual[i]), 0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Fresh DDL block after reset.
    for (int i = 0; i < 8; i++) top[i] = 8'(16 * i);
    for (int i = 0; i < 5; i++) left[i] = 8'd255;
    for (int i = 0; i < 16; i++) begin
      e_mb[i]   = 16 * (i % 4 + i / 4) + 16;
      e_pred[i] = e_mb[i];
    end
    e_mb[15] = 108;
    e_pred[15] = 108;
    run_block("post", 0);
    check_result("post", 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
